// File: rtl/latency_stat_pkg.sv
// Shared types and constants for the latency statistics arbiter.
// Min/max tracking is built only when LATENCY_STAT_MINMAX_EN is defined.
package latency_stat_pkg;

  localparam int LAT_WIDTH = 48;
  localparam logic [LAT_WIDTH-1:0] LAT_MIN_INIT = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lat_state_e;

  typedef struct packed {
    logic [LAT_WIDTH-1:0] lat_min;
    logic [LAT_WIDTH-1:0] lat_max;
  } lat_range_t;

  function automatic lat_range_t range_update(input lat_range_t cur,
                                              input logic [LAT_WIDTH-1:0] sample);
    lat_range_t nxt;
    nxt.lat_min = (sample < cur.lat_min) ? sample : cur.lat_min;
    nxt.lat_max = (sample > cur.lat_max) ? sample : cur.lat_max;
    return nxt;
  endfunction

endpackage

// File: rtl/latency_stat_arbiter_fifo.sv
// Per-source synchronous sample FIFO (latency_sample_fifo); push on full succeeds
// only when a pop happens in the same cycle.
module latency_sample_fifo
  import latency_stat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [LAT_WIDTH-1:0] din,
  output logic [LAT_WIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);

  logic [LAT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [AW:0]          r_cnt;
  logic                 w_push;
  logic                 w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == (AW+1)'(0));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr  <= AW'(0);
      r_rd  <= AW'(0);
      r_cnt <= (AW+1)'(0);
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/latency_stat_arbiter.sv
// Round-robin latency sample collector with per-source count/sum/drop statistics.
// Define LATENCY_STAT_MINMAX_EN to build the min/max trackers.
module latency_stat_arbiter
  import latency_stat_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SUM_WIDTH  = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_SRC-1:0]           src_latency_valid,
  input  logic [LAT_WIDTH*NUM_SRC-1:0] src_latency_data,
  input  logic                         ctrl_start,
  input  logic                         ctrl_stop,
  input  logic                         ctrl_clear,
  input  logic [$clog2(NUM_SRC)-1:0]   stat_sel,
  output logic [CNT_WIDTH-1:0]         stat_count,
  output logic [SUM_WIDTH-1:0]         stat_sum,
  output logic [LAT_WIDTH-1:0]         stat_min,
  output logic [LAT_WIDTH-1:0]         stat_max,
  output logic [CNT_WIDTH-1:0]         stat_drop,
  output logic                         stat_running,
  output logic                         stat_done
);
  localparam int IDX_W = $clog2(NUM_SRC);

  lat_state_e           r_state;
  logic                 r_running, r_done;
  logic [NUM_SRC-1:0]   w_push, w_pop, w_full, w_empty, w_drop;
  logic [LAT_WIDTH-1:0] w_fifo_dout [NUM_SRC];
  logic                 w_flush, w_arb_en, w_clear, w_gnt_vld;
  logic [IDX_W-1:0]     w_gnt_idx, r_last;
  logic                 r_s1_vld;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [LAT_WIDTH-1:0] r_s1_data;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_SRC];
  logic [CNT_WIDTH-1:0] r_drop [NUM_SRC];
  logic [SUM_WIDTH-1:0] r_sum [NUM_SRC];
  logic [CNT_WIDTH-1:0] r_out_cnt, r_out_drop;
  logic [SUM_WIDTH-1:0] r_out_sum;

  assign w_flush  = (r_state == ST_IDLE);
  assign w_arb_en = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_clear  = ctrl_clear && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_push[gi] = src_latency_valid[gi] && (r_state == ST_RUN);
    assign w_pop[gi]  = w_gnt_vld && (w_gnt_idx == IDX_W'(gi));
    assign w_drop[gi] = w_push[gi] && w_full[gi] && !w_pop[gi];

    latency_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .flush (w_flush),
      .push  (w_push[gi]),
      .pop   (w_pop[gi]),
      .din   (src_latency_data[LAT_WIDTH*gi +: LAT_WIDTH]),
      .dout  (w_fifo_dout[gi]),
      .full  (w_full[gi]),
      .empty (w_empty[gi])
    );
  end

  // Search starts one past the last granted index so every source gets a turn.
  always_comb begin
    int               w_j;
    logic [IDX_W-1:0] w_j_idx;
    logic             w_hit;
    w_gnt_vld = 1'b0;
    w_gnt_idx = {IDX_W{1'b0}};
    w_j       = 0;
    w_j_idx   = {IDX_W{1'b0}};
    w_hit     = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_j       = int'(r_last) + k;
      w_j       = (w_j >= NUM_SRC) ? w_j - NUM_SRC : w_j;
      w_j_idx   = IDX_W'(w_j);
      w_hit     = w_arb_en && !w_empty[w_j_idx] && !w_gnt_vld;
      w_gnt_idx = w_hit ? w_j_idx : w_gnt_idx;
      w_gnt_vld = w_gnt_vld || w_hit;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (ctrl_start) begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        ST_RUN: if (ctrl_stop) begin
          r_state   <= ST_DRAIN;
          r_running <= 1'b0;
        end
        ST_DRAIN: if ((&w_empty) && !r_s1_vld) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: if (ctrl_start) begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
          r_done    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_last    <= IDX_W'(NUM_SRC - 1);
      r_s1_vld  <= 1'b0;
      r_s1_idx  <= {IDX_W{1'b0}};
      r_s1_data <= {LAT_WIDTH{1'b0}};
    end else begin
      r_s1_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_last    <= w_gnt_idx;
        r_s1_idx  <= w_gnt_idx;
        r_s1_data <= w_fifo_dout[w_gnt_idx];
      end
    end
  end

`ifdef LATENCY_STAT_MINMAX_EN
  lat_range_t r_rng [NUM_SRC];
  lat_range_t r_out_rng;
`endif

  // Stage 2 reads the array written the previous cycle, so back-to-back hits on one source chain correctly.
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ap_rst || w_clear) begin
        r_cnt[i]  <= {CNT_WIDTH{1'b0}};
        r_drop[i] <= {CNT_WIDTH{1'b0}};
        r_sum[i]  <= {SUM_WIDTH{1'b0}};
`ifdef LATENCY_STAT_MINMAX_EN
        r_rng[i]  <= '{lat_min: LAT_MIN_INIT, lat_max: {LAT_WIDTH{1'b0}}};
`endif
      end else begin
        if (w_drop[i] && (r_drop[i] != {CNT_WIDTH{1'b1}})) begin
          r_drop[i] <= r_drop[i] + CNT_WIDTH'(1);
        end
        if (r_s1_vld && (r_s1_idx == IDX_W'(i))) begin
          if (r_cnt[i] != {CNT_WIDTH{1'b1}}) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
          r_sum[i] <= r_sum[i] + SUM_WIDTH'(r_s1_data);
`ifdef LATENCY_STAT_MINMAX_EN
          r_rng[i] <= range_update(r_rng[i], r_s1_data);
`endif
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_out_cnt  <= {CNT_WIDTH{1'b0}};
      r_out_sum  <= {SUM_WIDTH{1'b0}};
      r_out_drop <= {CNT_WIDTH{1'b0}};
`ifdef LATENCY_STAT_MINMAX_EN
      r_out_rng  <= '{lat_min: LAT_MIN_INIT, lat_max: {LAT_WIDTH{1'b0}}};
`endif
    end else if (int'(stat_sel) < NUM_SRC) begin
      r_out_cnt  <= r_cnt[stat_sel];
      r_out_sum  <= r_sum[stat_sel];
      r_out_drop <= r_drop[stat_sel];
`ifdef LATENCY_STAT_MINMAX_EN
      r_out_rng  <= r_rng[stat_sel];
`endif
    end else begin
      r_out_cnt  <= {CNT_WIDTH{1'b0}};
      r_out_sum  <= {SUM_WIDTH{1'b0}};
      r_out_drop <= {CNT_WIDTH{1'b0}};
`ifdef LATENCY_STAT_MINMAX_EN
      r_out_rng  <= '{lat_min: {LAT_WIDTH{1'b0}}, lat_max: {LAT_WIDTH{1'b0}}};
`endif
    end
  end

  assign stat_count   = r_out_cnt;
  assign stat_sum     = r_out_sum;
  assign stat_drop    = r_out_drop;
  assign stat_running = r_running;
  assign stat_done    = r_done;
`ifdef LATENCY_STAT_MINMAX_EN
  assign stat_min     = r_out_rng.lat_min;
  assign stat_max     = r_out_rng.lat_max;
`else
  assign stat_min     = {LAT_WIDTH{1'b0}};
  assign stat_max     = {LAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_latency_stat_arbiter.sv
// Directed and randomized checks of latency_stat_arbiter against a simple
// per-source statistics model; min/max expectations follow LATENCY_STAT_MINMAX_EN.
module tb_latency_stat_arbiter;
  localparam int NS = 2;
  localparam int LW = 48;
`ifdef LATENCY_STAT_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic [NS-1:0]  vld;
  logic [LW*NS-1:0] dat;
  logic           start, stop, clr;
  logic [0:0]     sel;
  logic [31:0]    stat_count, stat_drop;
  logic [63:0]    stat_sum;
  logic [47:0]    stat_min, stat_max;
  logic           stat_running, stat_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] c0, d0, c1, d1;
  logic [63:0] s0, s1;
  logic [31:0] m_cnt [NS];
  logic [63:0] m_sum [NS];
  logic [47:0] m_min [NS];
  logic [47:0] m_max [NS];
  bit          prev [NS];
  bit          want [NS];
  bit   [31:0] ra, rb;
  logic [47:0] rv [NS];

  latency_stat_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(4), .SUM_WIDTH(64), .CNT_WIDTH(32)) dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .src_latency_valid (vld),
    .src_latency_data  (dat),
    .ctrl_start        (start),
    .ctrl_stop         (stop),
    .ctrl_clear        (clr),
    .stat_sel          (sel),
    .stat_count        (stat_count),
    .stat_sum          (stat_sum),
    .stat_min          (stat_min),
    .stat_max          (stat_max),
    .stat_drop         (stat_drop),
    .stat_running      (stat_running),
    .stat_done         (stat_done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int s);
    sel = s[0];
    cyc(1);
  endtask

  task automatic drive(input logic [1:0] v, input logic [47:0] x0, input logic [47:0] x1);
    vld = v;
    dat = {x1, x0};
    cyc(1);
    vld = '0;
  endtask

  task automatic pulse(input int which);
    start = (which == 0);
    stop  = (which == 1);
    clr   = (which == 2);
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (stat_done !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk(tag, {63'd0, stat_done}, 64'd1);
  endtask

  task automatic check_stats(input string tag, input int s, input logic [31:0] cnt,
                             input logic [63:0] sum, input logic [47:0] mn,
                             input logic [47:0] mx, input logic [31:0] drp);
    rd(s);
    chk({tag, "_cnt"}, {32'd0, stat_count}, {32'd0, cnt});
    chk({tag, "_sum"}, stat_sum, sum);
    chk({tag, "_min"}, {16'd0, stat_min}, {16'd0, (MM ? mn : 48'd0)});
    chk({tag, "_max"}, {16'd0, stat_max}, {16'd0, (MM ? mx : 48'd0)});
    chk({tag, "_drop"}, {32'd0, stat_drop}, {32'd0, drp});
  endtask

  initial begin
    vld = '0; dat = '0; start = 1'b0; stop = 1'b0; clr = 1'b0; sel = 1'b0;
    ap_rst = 1'b1;
    cyc(2);
    chk("rst_cnt", {32'd0, stat_count}, 64'd0);
    chk("rst_sum", stat_sum, 64'd0);
    chk("rst_min", {16'd0, stat_min}, {16'd0, (MM ? ONES : 48'd0)});
    chk("rst_max", {16'd0, stat_max}, 64'd0);
    chk("rst_drop", {32'd0, stat_drop}, 64'd0);
    chk("rst_running", {63'd0, stat_running}, 64'd0);
    chk("rst_done", {63'd0, stat_done}, 64'd0);
    ap_rst = 1'b0;
    cyc(1);

    // basic window: 100, 200, 50 on source 0
    pulse(0);
    chk("t1_running", {63'd0, stat_running}, 64'd1);
    drive(2'b01, 48'd100, 48'd0);
    drive(2'b01, 48'd200, 48'd0);
    drive(2'b01, 48'd50, 48'd0);
    cyc(6);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_t1_running", {63'd0, stat_running}, 64'd0);
    chk("stop_t1_done", {63'd0, stat_done}, 64'd0);
    cyc(1);
    chk("stop_t2_done", {63'd0, stat_done}, 64'd1);
    check_stats("t1_s0", 0, 32'd3, 64'd350, 48'd50, 48'd200, 32'd0);
    check_stats("t1_s1", 1, 32'd0, 64'd0, ONES, 48'd0, 32'd0);

    // start and stop together in DONE: start wins
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("done_startstop_run", {63'd0, stat_running}, 64'd1);

    // sample-to-readout latency on source 1
    sel = 1'b1;
    cyc(1);
    drive(2'b10, 48'd0, 48'd500);
    cyc(2);
    chk("lat_t3", {32'd0, stat_count}, 64'd0);
    cyc(1);
    chk("lat_t4_cnt", {32'd0, stat_count}, 64'd1);
    chk("lat_t4_sum", stat_sum, 64'd500);

    pulse(2);
    cyc(2);
    chk("clr_in_run_ignored", {32'd0, stat_count}, 64'd1);

    // start and stop together in RUN: stop wins
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("run_startstop_stop", {63'd0, stat_running}, 64'd0);
    wait_done("t2_done");
    check_stats("t2_s1", 1, 32'd1, 64'd500, 48'd500, 48'd500, 32'd0);

    pulse(2);
    cyc(1);
    check_stats("clr_s1", 1, 32'd0, 64'd0, ONES, 48'd0, 32'd0);
    chk("clr_still_done", {63'd0, stat_done}, 64'd1);

    pulse(0);
    drive(2'b10, 48'd0, 48'd77);
    cyc(6);
    pulse(1);
    wait_done("fresh_done");
    check_stats("fresh_s1", 1, 32'd1, 64'd77, 48'd77, 48'd77, 32'd0);

    // sustained overload: both sources every cycle for 40 cycles
    pulse(2);
    pulse(0);
    for (int i = 0; i < 40; i++) drive(2'b11, 48'd10, 48'd20);
    pulse(1);
    wait_done("ovf_done");
    rd(0);
    c0 = stat_count; s0 = stat_sum; d0 = stat_drop;
    chk("ovf_min0", {16'd0, stat_min}, {16'd0, (MM ? 48'd10 : 48'd0)});
    rd(1);
    c1 = stat_count; s1 = stat_sum; d1 = stat_drop;
    chk("ovf_max1", {16'd0, stat_max}, {16'd0, (MM ? 48'd20 : 48'd0)});
    chk("ovf_total0", {32'd0, c0 + d0}, 64'd40);
    chk("ovf_total1", {32'd0, c1 + d1}, 64'd40);
    chk("ovf_sum0", s0, 64'(c0) * 64'd10);
    chk("ovf_sum1", s1, 64'(c1) * 64'd20);
    chk("ovf_drop0_nz", {63'd0, (d0 != 32'd0)}, 64'd1);
    chk("ovf_balance", {63'd0, ((c0 > c1 ? c0 - c1 : c1 - c0) <= 32'd1)}, 64'd1);

    // 8 strobes on both after reset: RR favours 0 first, so source 1 overflows once
    ap_rst = 1'b1; cyc(1); ap_rst = 1'b0;
    pulse(0);
    for (int i = 0; i < 8; i++) drive(2'b11, 48'd3, 48'd7);
    pulse(1);
    wait_done("b8_done");
    check_stats("b8_s0", 0, 32'd8, 64'd24, 48'd3, 48'd3, 32'd0);
    rd(1);
    chk("b8_drop1_nz", {63'd0, (stat_drop != 32'd0)}, 64'd1);
    chk("b8_total1", {32'd0, stat_count + stat_drop}, 64'd8);
    chk("b8_sum1", stat_sum, 64'(stat_count) * 64'd7);

    // stop with samples queued; strobes during DRAIN must not count
    ap_rst = 1'b1; cyc(1); ap_rst = 1'b0;
    sel = 1'b0;
    pulse(0);
    for (int k = 0; k < 3; k++) drive(2'b11, 48'(11 * (k + 1)), 48'(5 + k));
    pulse(1);
    begin
      int n;
      n = 0;
      while (stat_done !== 1'b1 && n < 100) begin
        vld = 2'b01;
        dat = {48'd0, 48'd999};
        cyc(1);
        n++;
      end
    end
    vld = '0;
    chk("drain_done", {63'd0, stat_done}, 64'd1);
    chk("drain_cnt_at_done", {32'd0, stat_count}, 64'd3);
    chk("drain_sum0", stat_sum, 64'd66);
    check_stats("drain_s1", 1, 32'd3, 64'd18, 48'd5, 48'd7, 32'd0);

    // randomized sparse traffic (each source at most every other cycle: no overflow)
    ap_rst = 1'b1; cyc(1); ap_rst = 1'b0;
    for (int s = 0; s < NS; s++) begin
      m_cnt[s] = 32'd0; m_sum[s] = 64'd0; m_min[s] = ONES; m_max[s] = 48'd0; prev[s] = 1'b0;
    end
    pulse(0);
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < NS; s++) begin
        ra = $urandom; rb = $urandom;
        rv[s]   = {ra[15:0], rb};
        want[s] = ($urandom_range(1, 0) == 1) && !prev[s];
        if (want[s]) begin
          m_cnt[s]++;
          m_sum[s] = m_sum[s] + 64'(rv[s]);
          if (rv[s] < m_min[s]) m_min[s] = rv[s];
          if (rv[s] > m_max[s]) m_max[s] = rv[s];
        end
        prev[s] = want[s];
      end
      vld = {want[1], want[0]};
      dat = {rv[1], rv[0]};
      cyc(1);
    end
    vld = '0;
    cyc(8);
    pulse(1);
    wait_done("rnd_done");
    for (int s = 0; s < NS; s++) check_stats($sformatf("rnd_s%0d", s), s, m_cnt[s], m_sum[s], m_min[s], m_max[s], 32'd0);

    // reset in the middle of RUN with samples pending
    pulse(0);
    for (int i = 0; i < 4; i++) drive(2'b11, 48'd123, 48'd456);
    ap_rst = 1'b1;
    cyc(1);
    chk("mrst_running", {63'd0, stat_running}, 64'd0);
    chk("mrst_done", {63'd0, stat_done}, 64'd0);
    chk("mrst_cnt", {32'd0, stat_count}, 64'd0);
    chk("mrst_sum", stat_sum, 64'd0);
    chk("mrst_min", {16'd0, stat_min}, {16'd0, (MM ? ONES : 48'd0)});
    chk("mrst_max", {16'd0, stat_max}, 64'd0);
    chk("mrst_drop", {32'd0, stat_drop}, 64'd0);
    ap_rst = 1'b0;
    pulse(0);
    cyc(4);
    pulse(1);
    wait_done("mrst_done2");
    check_stats("mrst_s0", 0, 32'd0, 64'd0, ONES, 48'd0, 32'd0);
    check_stats("mrst_s1", 1, 32'd0, 64'd0, ONES, 48'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
